// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester word arbiter.
package mips_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } arb_state_t;

   localparam int   CNT_W    = 4;
   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

   // Ownership state that follows an accepted beat from src.
   function automatic arb_state_t own_state(input logic src);
      return (src == SRC_REQ1) ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// Existing 2:1 word mux: sel=0 passes in1, sel=1 passes in2.
module mux_arbiter_mux #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in2 : in1;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing one word datapath,
// with a one-entry registered output stage and a per-owner burst limit.
//
// state | meaning
// IDLE  | no current owner; grant goes to !last when both request
// OWN0  | requester 0 accepted the last beat and may keep streaming
// OWN1  | requester 1 accepted the last beat and may keep streaming
module mux_arbiter
   import mips_arb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   arb_state_t       state_q;
   logic             last_q;
   logic             sel_q;
   logic [CNT_W-1:0] burst_cnt_q;
   logic             grant;
   logic             can_load;
   logic             accept;
   logic             under_limit;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] mux_data;

   mux_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
      .sel (grant),
      .in1 (req0_data),
      .in2 (req1_data),
      .out (mux_data)
   );

   assign under_limit = (burst_cnt_q < BURST_MAX);
   assign cnt_inc     = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + CNT_W'(1);
   assign can_load    = !out_valid || out_ready;
   assign req0_ready  = can_load && (grant == SRC_REQ0) && req0_valid && !rst;
   assign req1_ready  = can_load && (grant == SRC_REQ1) && req1_valid && !rst;
   assign accept      = req0_ready || req1_ready;
   assign sel         = grant;

   // Grant selection from registered ownership and the live valids.
   always_comb begin
      grant = sel_q;
      case (state_q)
         IDLE: begin
            if (req0_valid && req1_valid) grant = !last_q;
            else if (req0_valid)          grant = SRC_REQ0;
            else if (req1_valid)          grant = SRC_REQ1;
         end
         OWN0: begin
            if (req0_valid && (under_limit || !req1_valid)) grant = SRC_REQ0;
            else if (req1_valid)                            grant = SRC_REQ1;
            else                                            grant = SRC_REQ0;
         end
         OWN1: begin
            if (req1_valid && (under_limit || !req0_valid)) grant = SRC_REQ1;
            else if (req0_valid)                            grant = SRC_REQ0;
            else                                            grant = SRC_REQ1;
         end
         default: grant = sel_q;
      endcase
   end

   // Ownership, burst count and output register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         sel_q       <= 1'b0;
         burst_cnt_q <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_src     <= 1'b0;
      end else begin
         sel_q <= grant;
         if (accept) begin
            out_data    <= mux_data;
            out_src     <= grant;
            out_valid   <= 1'b1;
            last_q      <= grant;
            state_q     <= own_state(grant);
            burst_cnt_q <= (state_q == own_state(grant)) ? cnt_inc : CNT_W'(1);
         end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            // An owner that drops valid gives up ownership; last is kept for fairness.
            if ((state_q == OWN0 && !req0_valid) || (state_q == OWN1 && !req1_valid)) begin
               state_q     <= IDLE;
               burst_cnt_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: instance a uses MAX_BURST=4, instance b MAX_BURST=1.
module tb_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_v0, a_v1, a_ordy, b_v0, b_v1, b_ordy;
   logic [31:0] a_d0, a_d1, b_d0, b_d1;
   logic        a_r0, a_r1, a_sel, a_ov, a_os;
   logic        b_r0, b_r1, b_sel, b_ov, b_os;
   logic [31:0] a_od, b_od;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
      .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
      .sel(a_sel), .out_valid(a_ov), .out_data(a_od), .out_src(a_os),
      .out_ready(a_ordy)
   );

   mux_arbiter #(.WIDTH(32), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
      .sel(b_sel), .out_valid(b_ov), .out_data(b_od), .out_src(b_os),
      .out_ready(b_ordy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] single_words [3];
   logic        burst_src [9];
   int          idx0, idx1;
   logic [31:0] exp_word;

   initial begin
      single_words = '{32'h11, 32'h22, 32'h33};
      burst_src    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst  = 1'b1;
      a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = 32'hA0; a_d1 = 32'hB0; a_ordy = 1'b1;
      b_v0 = 1'b1; b_v1 = 1'b1; b_d0 = 32'hA0; b_d1 = 32'hB0; b_ordy = 1'b1;

      // reset held two cycles with both valids high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", 32'(a_r0), 32'd0);
      chk("rst_ready1", 32'(a_r1), 32'd0);
      chk("rst_out_valid", 32'(a_ov), 32'd0);
      chk("rst_out_data", a_od, 32'd0);
      chk("rst_out_src", 32'(a_os), 32'd0);
      chk("rst_sel", 32'(a_sel), 32'd0);
      chk("rst_b_ready0", 32'(b_r0), 32'd0);
      next_cycle();
      rst = 1'b0;

      // simultaneous first request: req0 wins on both instances
      @(negedge clk);
      chk("first_sel", 32'(a_sel), 32'd0);
      chk("first_ready0", 32'(a_r0), 32'd1);
      chk("first_ready1", 32'(a_r1), 32'd0);
      chk("first_b_sel", 32'(b_sel), 32'd0);
      next_cycle();
      chk("first_out_valid", 32'(a_ov), 32'd1);
      chk("first_out_data", a_od, 32'hA0);
      chk("first_out_src", 32'(a_os), 32'd0);
      chk("first_b_out_data", b_od, 32'hA0);
      chk("first_b_out_src", 32'(b_os), 32'd0);

      // MAX_BURST=1 hands the next beat to req1; instance a drains
      a_v0 = 1'b0; a_v1 = 1'b0;
      b_d0 = 32'hA1;
      @(negedge clk);
      chk("b_second_sel", 32'(b_sel), 32'd1);
      chk("b_second_ready1", 32'(b_r1), 32'd1);
      chk("b_second_ready0", 32'(b_r0), 32'd0);
      next_cycle();
      chk("b_second_out_data", b_od, 32'hB0);
      chk("b_second_out_src", 32'(b_os), 32'd1);
      chk("a_drain_valid", 32'(a_ov), 32'd0);
      chk("a_drain_stale_data", a_od, 32'hA0);
      b_v0 = 1'b0; b_v1 = 1'b0;

      // single requester stream
      for (int i = 0; i < 3; i++) begin
         a_v0 = 1'b1; a_d0 = single_words[i];
         @(negedge clk);
         chk("single_ready0", 32'(a_r0), 32'd1);
         next_cycle();
         chk("single_out_data", a_od, single_words[i]);
         chk("single_out_src", 32'(a_os), 32'd0);
         chk("single_out_valid", 32'(a_ov), 32'd1);
      end
      a_v0 = 1'b0;

      // fresh reset so req0 wins the first contended grant
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;

      // burst limit with both requesters valid continuously
      idx0 = 0; idx1 = 0;
      for (int k = 0; k < 9; k++) begin
         a_v0 = 1'b1; a_v1 = 1'b1;
         a_d0 = 32'h100 + 32'(idx0);
         a_d1 = 32'h200 + 32'(idx1);
         @(negedge clk);
         chk("burst_sel", 32'(a_sel), 32'(burst_src[k]));
         exp_word = burst_src[k] ? (32'h200 + 32'(idx1)) : (32'h100 + 32'(idx0));
         next_cycle();
         chk("burst_out_src", 32'(a_os), 32'(burst_src[k]));
         chk("burst_out_data", a_od, exp_word);
         if (burst_src[k]) idx1++;
         else              idx0++;
      end

      // backpressure: three stalled cycles, then load with no bubble
      a_d0 = 32'h105; a_d1 = 32'h204; a_ordy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stall_ready0", 32'(a_r0), 32'd0);
         chk("stall_ready1", 32'(a_r1), 32'd0);
         chk("stall_out_valid", 32'(a_ov), 32'd1);
         chk("stall_out_data", a_od, 32'h104);
         next_cycle();
      end
      a_ordy = 1'b1;
      @(negedge clk);
      chk("unstall_ready0", 32'(a_r0), 32'd1);
      next_cycle();
      chk("unstall_out_data", a_od, 32'h105);
      chk("unstall_out_valid", 32'(a_ov), 32'd1);
      chk("unstall_out_src", 32'(a_os), 32'd0);

      // reset mid-burst (owner 0, two beats counted, beat buffered)
      a_d0 = 32'h106;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready0", 32'(a_r0), 32'd0);
      chk("midrst_ready1", 32'(a_r1), 32'd0);
      next_cycle();
      chk("midrst_out_valid", 32'(a_ov), 32'd0);
      chk("midrst_out_data", a_od, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_sel", 32'(a_sel), 32'd0);
      chk("postrst_ready0", 32'(a_r0), 32'd1);
      next_cycle();
      chk("postrst_out_data", a_od, 32'h106);
      chk("postrst_out_src", 32'(a_os), 32'd0);

      // req1 alone streams past the limit, then req0 gets the grant at once
      a_v0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a_v1 = 1'b1; a_d1 = 32'h300 + 32'(i);
         @(negedge clk);
         chk("solo1_ready1", 32'(a_r1), 32'd1);
         next_cycle();
         chk("solo1_out_data", a_od, 32'h300 + 32'(i));
      end
      a_v0 = 1'b1; a_d0 = 32'h107; a_d1 = 32'h306;
      @(negedge clk);
      chk("sat_switch_sel", 32'(a_sel), 32'd0);
      next_cycle();
      chk("sat_switch_out_data", a_od, 32'h107);
      chk("sat_switch_out_src", 32'(a_os), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
